// File: rtl/tele_pkg.sv
// Shared encodings and defaults for the caller and callee telephone FSMs.
// Both sides use 3-bit state codes so traces line up across the link.
package tele_pkg;

    // Caller (dialling side) state codes
    localparam logic [2:0] CALLER_IDLE = 3'd0;
    localparam logic [2:0] CALLER_DIAL = 3'd1;
    localparam logic [2:0] CALLER_WAIT = 3'd2;
    localparam logic [2:0] CALLER_TALK = 3'd3;
    localparam logic [2:0] CALLER_DONE = 3'd4;

    // Callee (answering side) state codes
    localparam logic [2:0] RX_IDLE         = 3'd0;
    localparam logic [2:0] RX_RING         = 3'd1;
    localparam logic [2:0] RX_CONNECTED    = 3'd2;
    localparam logic [2:0] RX_CALL_TIMEOUT = 3'd3;
    localparam logic [2:0] RX_HANGUP       = 3'd4;
    localparam logic [2:0] RX_MISSED       = 3'd5;

    localparam int RING_MAX_DEF = 5;
    localparam int CALL_MAX_DEF = 250;
    localparam int CNT_W_DEF    = 8;
    localparam int MISSED_W_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE         = RX_IDLE,
        ST_RING         = RX_RING,
        ST_CONNECTED    = RX_CONNECTED,
        ST_CALL_TIMEOUT = RX_CALL_TIMEOUT,
        ST_HANGUP       = RX_HANGUP,
        ST_MISSED       = RX_MISSED
    } rx_state_e;

endpackage

// File: rtl/tele_rx_fsm_if.sv
// Line/user signal bundle for the callee controller.
// master drives the line and keypad, slave is the controller.
interface tele_rx_fsm_if #(
    parameter int CNT_W    = 8,
    parameter int MISSED_W = 4
);
    logic                incoming_call;
    logic                answer;
    logic                reject;
    logic                hang_up;
    logic                remote_end;
    logic                ringing;
    logic                in_call;
    logic                call_timeout;
    logic                call_ended;
    logic                missed_call;
    logic                busy;
    logic [CNT_W-1:0]    call_timer;
    logic [MISSED_W-1:0] missed_count;

    modport master (
        output incoming_call, answer, reject, hang_up, remote_end,
        input  ringing, in_call, call_timeout, call_ended,
        input  missed_call, busy, call_timer, missed_count
    );

    modport slave (
        input  incoming_call, answer, reject, hang_up, remote_end,
        output ringing, in_call, call_timeout, call_ended,
        output missed_call, busy, call_timer, missed_count
    );
endinterface

// File: rtl/tele_sat_counter.sv
// Clear/increment counter; SAT=1 sticks at all-ones, SAT=0 wraps.
// Clear has priority over increment.
module tele_sat_counter #(
    parameter int W   = 8,
    parameter bit SAT = 1'b0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    localparam logic [W-1:0] MAX = '1;

    logic at_max;
    assign at_max = SAT && (q == MAX);

    // Count register: clear, or step unless pinned at saturation
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc && !at_max)
            q <= q + 1'b1;
    end
endmodule

// File: rtl/tele_rx_fsm.sv
// Callee-side call controller: ring, answer/reject/miss, timed call.
// Build option TELE_RX_AUTO_ANSWER_EN: ring expiry connects instead of missing.
module tele_rx_fsm
    import tele_pkg::*;
#(
    parameter int RING_MAX = RING_MAX_DEF,
    parameter int CALL_MAX = CALL_MAX_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int MISSED_W = MISSED_W_DEF
) (
    input logic          clk,
    input logic          reset_n,
    tele_rx_fsm_if.slave bus
);
`ifdef TELE_RX_AUTO_ANSWER_EN
    localparam rx_state_e EXPIRE_ST = ST_CONNECTED;
`else
    localparam rx_state_e EXPIRE_ST = ST_MISSED;
`endif

    rx_state_e           state;
    rx_state_e           state_nx;
    logic                ring_inc;
    logic                call_inc;
    logic                ring_last;
    logic                call_last;
    logic                in_idle;
    logic [CNT_W-1:0]    ring_cnt;
    logic [CNT_W-1:0]    call_cnt;
    logic [MISSED_W-1:0] missed_cnt;

    assign ring_last = (ring_cnt == CNT_W'(RING_MAX - 1));
    assign call_last = (call_cnt == CNT_W'(CALL_MAX - 1));
    assign in_idle   = (state == ST_IDLE);

    // Next state and counter steps, events in priority order
    always_comb begin
        state_nx = state;
        ring_inc = 1'b0;
        call_inc = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.incoming_call)
                    state_nx = ST_RING;
            end
            ST_RING: begin
                if (!bus.incoming_call)
                    state_nx = ST_MISSED;
                else if (bus.reject)
                    state_nx = ST_HANGUP;
                else if (bus.answer)
                    state_nx = ST_CONNECTED;
                else if (ring_last)
                    state_nx = EXPIRE_ST;
                else
                    ring_inc = 1'b1;
            end
            ST_CONNECTED: begin
                if (call_last)
                    state_nx = ST_CALL_TIMEOUT;
                else if (bus.hang_up || bus.remote_end)
                    state_nx = ST_HANGUP;
                else
                    call_inc = 1'b1;
            end
            ST_CALL_TIMEOUT: begin
                if (bus.hang_up)
                    state_nx = ST_IDLE;
            end
            ST_HANGUP, ST_MISSED: state_nx = ST_IDLE;
            default:              state_nx = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    tele_sat_counter #(.W(CNT_W), .SAT(1'b0)) u_ring_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (in_idle),
        .inc     (ring_inc),
        .q       (ring_cnt)
    );

    tele_sat_counter #(.W(CNT_W), .SAT(1'b0)) u_call_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (in_idle),
        .inc     (call_inc),
        .q       (call_cnt)
    );

    tele_sat_counter #(.W(MISSED_W), .SAT(1'b1)) u_missed_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (1'b0),
        .inc     (state == ST_MISSED),
        .q       (missed_cnt)
    );

    assign bus.ringing      = (state == ST_RING);
    assign bus.in_call      = (state == ST_CONNECTED);
    assign bus.call_timeout = (state == ST_CALL_TIMEOUT);
    assign bus.call_ended   = (state == ST_HANGUP) ||
                              (state == ST_CALL_TIMEOUT);
    assign bus.missed_call  = (state == ST_MISSED);
    assign bus.busy         = !in_idle;
    assign bus.call_timer   = call_cnt;
    assign bus.missed_count = missed_cnt;
endmodule

// File: tb/tb_tele_rx_fsm.sv
// Testbench for tele_rx_fsm: directed scenarios plus random traffic,
// all checked against a call-level behavioural model.
module tb_tele_rx_fsm;
    localparam int RING_MAX = 5;
    localparam int CALL_MAX = 250;
    localparam int CNT_W    = 8;
    localparam int MISSED_W = 4;
    localparam int VW       = 6 + CNT_W + MISSED_W;
    localparam int MC_MAX   = (1 << MISSED_W) - 1;

    localparam int P_IDLE = 0;
    localparam int P_RING = 1;
    localparam int P_TALK = 2;
    localparam int P_TOUT = 3;
    localparam int P_HANG = 4;
    localparam int P_MISS = 5;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    int nvec = 0;
    int nerr = 0;

    int m_mode;
    int m_rc;
    int m_cc;
    int m_mc;

    always #5 clk = ~clk;

    tele_rx_fsm_if #(.CNT_W(CNT_W), .MISSED_W(MISSED_W)) bus ();

    tele_rx_fsm #(
        .RING_MAX (RING_MAX),
        .CALL_MAX (CALL_MAX),
        .CNT_W    (CNT_W),
        .MISSED_W (MISSED_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic model_reset();
        m_mode = P_IDLE;
        m_rc = 0;
        m_cc = 0;
        m_mc = 0;
    endtask

    task automatic model_step();
        case (m_mode)
            P_IDLE: begin
                m_rc = 0;
                m_cc = 0;
                if (bus.incoming_call) m_mode = P_RING;
            end
            P_RING: begin
                if (!bus.incoming_call) m_mode = P_MISS;
                else if (bus.reject) m_mode = P_HANG;
                else if (bus.answer) m_mode = P_TALK;
                else if (m_rc + 1 == RING_MAX) begin
`ifdef TELE_RX_AUTO_ANSWER_EN
                    m_mode = P_TALK;
`else
                    m_mode = P_MISS;
`endif
                end
                else m_rc++;
            end
            P_TALK: begin
                if (m_cc + 1 == CALL_MAX) m_mode = P_TOUT;
                else if (bus.hang_up || bus.remote_end) m_mode = P_HANG;
                else m_cc++;
            end
            P_TOUT: if (bus.hang_up) m_mode = P_IDLE;
            P_HANG: m_mode = P_IDLE;
            P_MISS: begin
                if (m_mc < MC_MAX) m_mc++;
                m_mode = P_IDLE;
            end
            default: m_mode = P_IDLE;
        endcase
    endtask

    function automatic logic [VW-1:0] exp_vec();
        return {m_mode == P_RING, m_mode == P_TALK, m_mode == P_TOUT,
                (m_mode == P_HANG) || (m_mode == P_TOUT),
                m_mode == P_MISS, m_mode != P_IDLE,
                CNT_W'(m_cc), MISSED_W'(m_mc)};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {bus.ringing, bus.in_call, bus.call_timeout, bus.call_ended,
                bus.missed_call, bus.busy, bus.call_timer, bus.missed_count};
    endfunction

    task automatic set_in(input logic ic, input logic an, input logic rj,
                          input logic hu, input logic re);
        bus.incoming_call = ic;
        bus.answer = an;
        bus.reject = rj;
        bus.hang_up = hu;
        bus.remote_end = re;
    endtask

    task automatic cyc();
        @(posedge clk);
        if (reset_n) model_step();
        else model_reset();
        #1;
    endtask

    task automatic test_reset();
        set_in(0, 0, 0, 0, 0);
        model_reset();
        #1;
        nvec++;
        if (obs_vec() !== '0) begin
            nerr++;
            $display("FAIL reset_init: got %h want 0", obs_vec());
        end
        cyc();
        cyc();
        reset_n = 1'b1;
        set_in(1, 0, 0, 0, 0);
        cyc();
        set_in(1, 1, 0, 0, 0);
        cyc();
        set_in(0, 0, 0, 0, 0);
        for (int i = 0; i < 37; i++) begin
            nvec++;
            if (obs_vec() !== exp_vec()) begin
                nerr++;
                $display("FAIL reset_call%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            cyc();
        end
        nvec++;
        if (bus.call_timer !== CNT_W'(37) || bus.in_call !== 1'b1) begin
            nerr++;
            $display("FAIL reset_timer37: got %0d/%b want 37/1", bus.call_timer, bus.in_call);
        end
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        nvec++;
        if (obs_vec() !== '0) begin
            nerr++;
            $display("FAIL reset_async: got %h want 0", obs_vec());
        end
        cyc();
        nvec++;
        if (obs_vec() !== '0) begin
            nerr++;
            $display("FAIL reset_hold: got %h want 0", obs_vec());
        end
        reset_n = 1'b1;
        cyc();
        nvec++;
        if (obs_vec() !== exp_vec()) begin
            nerr++;
            $display("FAIL reset_release: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_missed();
        int rings = 0;
        int mc0 = m_mc;
        set_in(1, 0, 0, 0, 0);
        cyc();
        for (int i = 0; i < 20 && bus.ringing; i++) begin
            nvec++;
            if (obs_vec() !== exp_vec()) begin
                nerr++;
                $display("FAIL missed_ring%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            rings++;
            cyc();
        end
        nvec++;
        if (rings != RING_MAX) begin
            nerr++;
            $display("FAIL missed_ringlen: got %0d want %0d", rings, RING_MAX);
        end
`ifdef TELE_RX_AUTO_ANSWER_EN
        nvec++;
        if (bus.in_call !== 1'b1 || bus.missed_call !== 1'b0) begin
            nerr++;
            $display("FAIL auto_answer: got in_call=%b missed=%b want 1/0", bus.in_call, bus.missed_call);
        end
`else
        nvec++;
        if (bus.missed_call !== 1'b1) begin
            nerr++;
            $display("FAIL missed_pulse: got %b want 1", bus.missed_call);
        end
`endif
        set_in(0, 0, 0, 1, 0);
        cyc();
        set_in(0, 0, 0, 0, 0);
        cyc();
        cyc();
        nvec++;
        if (obs_vec() !== exp_vec()) begin
            nerr++;
            $display("FAIL missed_after: got %h want %h", obs_vec(), exp_vec());
        end
`ifdef TELE_RX_AUTO_ANSWER_EN
        nvec++;
        if (bus.busy !== 1'b0 || bus.missed_count !== MISSED_W'(mc0)) begin
            nerr++;
            $display("FAIL auto_count: got busy=%b cnt=%0d want 0/%0d", bus.busy, bus.missed_count, mc0);
        end
`else
        nvec++;
        if (bus.busy !== 1'b0 || bus.missed_count !== MISSED_W'(mc0 + 1)) begin
            nerr++;
            $display("FAIL missed_count: got busy=%b cnt=%0d want 0/%0d", bus.busy, bus.missed_count, mc0 + 1);
        end
`endif
    endtask

    task automatic test_answer_remote();
        int talk = 0;
        set_in(1, 0, 0, 0, 0);
        cyc();
        cyc();
        cyc();
        set_in(1, 1, 0, 0, 0);
        cyc();
        set_in(0, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            nvec++;
            if (obs_vec() !== exp_vec()) begin
                nerr++;
                $display("FAIL answer_talk%0d: got %h want %h", k, obs_vec(), exp_vec());
            end
            if (bus.in_call) talk++;
            if (k == 9) bus.remote_end = 1'b1;
            cyc();
        end
        bus.remote_end = 1'b0;
        nvec++;
        if (talk != 10 || bus.call_timer !== CNT_W'(9) || bus.call_ended !== 1'b1) begin
            nerr++;
            $display("FAIL answer_hangup: got talk=%0d timer=%0d ended=%b want 10/9/1",
                     talk, bus.call_timer, bus.call_ended);
        end
        cyc();
        nvec++;
        if (obs_vec() !== exp_vec() || bus.busy !== 1'b0) begin
            nerr++;
            $display("FAIL answer_idle: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_timeout();
        int talk = 0;
        set_in(1, 0, 0, 0, 0);
        cyc();
        set_in(1, 1, 0, 0, 0);
        cyc();
        set_in(0, 0, 0, 0, 0);
        for (int i = 0; i < CALL_MAX + 20; i++) begin
            nvec++;
            if (obs_vec() !== exp_vec()) begin
                nerr++;
                $display("FAIL timeout_talk%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            if (!bus.in_call) break;
            talk++;
            bus.hang_up = (bus.call_timer == CNT_W'(CALL_MAX - 1));
            cyc();
        end
        bus.hang_up = 1'b0;
        nvec++;
        if (talk != CALL_MAX || bus.call_timeout !== 1'b1 || bus.call_ended !== 1'b1) begin
            nerr++;
            $display("FAIL timeout_enter: got talk=%0d to=%b ended=%b want %0d/1/1",
                     talk, bus.call_timeout, bus.call_ended, CALL_MAX);
        end
        bus.remote_end = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            nvec++;
            if (obs_vec() !== exp_vec()) begin
                nerr++;
                $display("FAIL timeout_hold%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        set_in(0, 0, 0, 1, 0);
        cyc();
        set_in(0, 0, 0, 0, 0);
        nvec++;
        if (obs_vec() !== exp_vec() || bus.busy !== 1'b0) begin
            nerr++;
            $display("FAIL timeout_exit: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_priority();
        set_in(1, 0, 0, 0, 0);
        cyc();
        set_in(1, 1, 1, 0, 0);
        cyc();
        nvec++;
        if (obs_vec() !== exp_vec() || bus.call_ended !== 1'b1 || bus.in_call !== 1'b0) begin
            nerr++;
            $display("FAIL prio_reject: got %h want %h", obs_vec(), exp_vec());
        end
        set_in(0, 0, 0, 0, 0);
        cyc();
        set_in(1, 0, 0, 0, 0);
        cyc();
        set_in(0, 1, 0, 0, 0);
        cyc();
        nvec++;
        if (obs_vec() !== exp_vec() || bus.missed_call !== 1'b1) begin
            nerr++;
            $display("FAIL prio_cancel: got %h want %h", obs_vec(), exp_vec());
        end
        set_in(0, 0, 0, 0, 0);
        cyc();
    endtask

    task automatic test_saturate();
        for (int n = 0; n < 17; n++) begin
            set_in(1, 0, 0, 0, 0);
            cyc();
            cyc();
            bus.incoming_call = 1'b0;
            cyc();
            nvec++;
            if (obs_vec() !== exp_vec()) begin
                nerr++;
                $display("FAIL sat_miss%0d: got %h want %h", n, obs_vec(), exp_vec());
            end
            cyc();
        end
        nvec++;
        if (bus.missed_count !== MISSED_W'(MC_MAX)) begin
            nerr++;
            $display("FAIL sat_value: got %0d want %0d", bus.missed_count, MC_MAX);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            set_in($urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0,
                   $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
                   $urandom_range(0, 19) == 0);
            cyc();
            nvec++;
            if (obs_vec() !== exp_vec()) begin
                nerr++;
                $display("FAIL random%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        set_in(0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_missed();
        test_answer_remote();
        test_timeout();
        test_priority();
        test_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
